// File: rtl/key_pulse_stretcher.sv
// key_pulse_stretcher
//   Turns one-cycle event pulses into timed level windows. Every accepted
//   event yields `level` high for HOLD_CYCLES cycles followed by at least
//   GAP_CYCLES low cycles. Events arriving while a window is running are
//   counted in a saturating pending counter and replayed as later windows.
//
// Ports
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset
//   p_key    in  one-cycle event pulse (one event per high cycle)
//   clear    in  synchronous abort: drops the current window and the queue
//   level    out stretched window (registered)
//   busy     out high whenever a window or its gap is in progress
//   pending  out number of queued events
//   overflow out one-cycle pulse when an event is dropped on a full queue
module key_pulse_stretcher #(
  parameter int HOLD_CYCLES = 5_000_000,
  parameter int GAP_CYCLES  = 2_500_000,
  parameter int MAX_PENDING = 7
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               p_key,
  input  logic                               clear,
  output logic                               level,
  output logic                               busy,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
  output logic                               overflow
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam int PW = $clog2(MAX_PENDING + 1);

  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PENDING);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [PW-1:0]   pending_reg;
  logic            level_reg;
  logic            busy_reg;
  logic            overflow_reg;

  // Outputs are decoded from the next state inside the sequential block so
  // that they change on the same edge as the state itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      pending_reg  <= '0;
      level_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      overflow_reg <= 1'b0;
      if (clear) begin
        // Abort wins over everything, including a coincident event.
        state_reg   <= IDLE;
        cnt_reg     <= '0;
        pending_reg <= '0;
        level_reg   <= 1'b0;
        busy_reg    <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (p_key) begin
              state_reg <= HIGH;
              cnt_reg   <= HOLD_LOAD;
              level_reg <= 1'b1;
              busy_reg  <= 1'b1;
            end
          end

          HIGH: begin
            if (cnt_reg != '0) begin
              cnt_reg <= cnt_reg - 1'b1;
            end else begin
              state_reg <= GAP;
              cnt_reg   <= GAP_LOAD;
              level_reg <= 1'b0;
            end
            if (p_key) begin
              if (pending_reg < PEND_MAX) pending_reg <= pending_reg + 1'b1;
              else                        overflow_reg <= 1'b1;
            end
          end

          GAP: begin
            if (cnt_reg != '0) begin
              cnt_reg <= cnt_reg - 1'b1;
              if (p_key) begin
                if (pending_reg < PEND_MAX) pending_reg <= pending_reg + 1'b1;
                else                        overflow_reg <= 1'b1;
              end
            end else if (pending_reg != '0 || p_key) begin
              // Last gap cycle: a coincident event is consumed directly by
              // the next window, so a full queue never overflows here.
              state_reg <= HIGH;
              cnt_reg   <= HOLD_LOAD;
              level_reg <= 1'b1;
              if (!p_key) pending_reg <= pending_reg - 1'b1;
            end else begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end

          default: begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign level    = level_reg;
  assign busy     = busy_reg;
  assign pending  = pending_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_key_pulse_stretcher.sv
module tb_key_pulse_stretcher;

  localparam int H  = 4;
  localparam int G  = 2;
  localparam int MP = 3;
  localparam int PW = $clog2(MP + 1);
  localparam int LEN = 40;

  logic clk = 1'b0;
  logic reset_n;
  logic p_key;
  logic clear;
  logic level;
  logic busy;
  logic [PW-1:0] pending;
  logic overflow;

  key_pulse_stretcher #(
    .HOLD_CYCLES(H),
    .GAP_CYCLES (G),
    .MAX_PENDING(MP)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .p_key   (p_key),
    .clear   (clear),
    .level   (level),
    .busy    (busy),
    .pending (pending),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Timeline model: a window is described only by the cycle it starts on.
  bit m_active;
  int m_start;
  int m_pend;
  bit m_ovf;

  int cur_c;
  int scn;
  bit chk_en;

  task automatic model_reset();
    m_active = 1'b0;
    m_start  = -1000;
    m_pend   = 0;
    m_ovf    = 1'b0;
  endtask

  // Advance the model across the edge that ends cycle c.
  task automatic model_step(input bit p, input bit cl, input int c);
    bit inwin;
    int eff;
    m_ovf = 1'b0;
    if (cl) begin
      m_active = 1'b0;
      m_pend   = 0;
    end else begin
      inwin = m_active && (c >= m_start) && (c <= m_start + H + G - 1);
      if (!inwin) begin
        m_active = 1'b0;
        if (p) begin
          m_active = 1'b1;
          m_start  = c + 1;
        end
      end else if (c == m_start + H + G - 1) begin
        eff = m_pend + (p ? 1 : 0);
        if (eff > 0) begin
          m_start = c + 1;
          m_pend  = eff - 1;
        end else begin
          m_active = 1'b0;
        end
      end else if (p) begin
        if (m_pend < MP) m_pend = m_pend + 1;
        else             m_ovf  = 1'b1;
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s scn %0d cycle %0d: got %0d, expected %0d", name, scn, cur_c, act, exp);
    end
  endtask

  // Single compare process: model every cycle, plus hand-computed pins.
  always @(negedge clk) begin
    if (chk_en) begin
      check("level",    int'(level),    int'(m_active && cur_c >= m_start && cur_c < m_start + H));
      check("busy",     int'(busy),     int'(m_active && cur_c >= m_start && cur_c < m_start + H + G));
      check("pending",  int'(pending),  m_pend);
      check("overflow", int'(overflow), int'(m_ovf));

      case (scn)
        1: begin
          if (cur_c == 11) check("pin_s1_level11", int'(level), 1);
          if (cur_c == 14) check("pin_s1_level14", int'(level), 1);
          if (cur_c == 15) check("pin_s1_level15", int'(level), 0);
          if (cur_c == 16) check("pin_s1_busy16",  int'(busy),  1);
          if (cur_c == 17) check("pin_s1_busy17",  int'(busy),  0);
        end
        2: begin
          if (cur_c == 13) check("pin_s2_pend13",  int'(pending), 1);
          if (cur_c == 14) check("pin_s2_pend14",  int'(pending), 2);
          if (cur_c == 17) check("pin_s2_pend17",  int'(pending), 1);
          if (cur_c == 22) check("pin_s2_level22", int'(level),   0);
          if (cur_c == 23) check("pin_s2_level23", int'(level),   1);
          if (cur_c == 23) check("pin_s2_pend23",  int'(pending), 0);
        end
        3: begin
          if (cur_c == 14) check("pin_s3_pend14", int'(pending),  3);
          if (cur_c == 15) check("pin_s3_ovf15",  int'(overflow), 1);
          if (cur_c == 16) check("pin_s3_ovf16",  int'(overflow), 1);
          if (cur_c == 17) check("pin_s3_ovf17",  int'(overflow), 0);
          if (cur_c == 29) check("pin_s3_lvl29",  int'(level),    1);
          if (cur_c == 32) check("pin_s3_lvl32",  int'(level),    1);
          if (cur_c == 33) check("pin_s3_lvl33",  int'(level),    0);
        end
        4: begin
          if (cur_c == 17) check("pin_s4_level17", int'(level),   1);
          if (cur_c == 17) check("pin_s4_pend17",  int'(pending), 0);
          if (cur_c == 20) check("pin_s4_level20", int'(level),   1);
          if (cur_c == 21) check("pin_s4_level21", int'(level),   0);
        end
        5: begin
          if (cur_c == 13) check("pin_s5_pend13", int'(pending), 1);
          if (cur_c == 14) check("pin_s5_busy14", int'(busy),    0);
          if (cur_c == 14) check("pin_s5_pend14", int'(pending), 0);
          if (cur_c == 16) check("pin_s5_lvl16",  int'(level),   0);
        end
        6: begin
          if (cur_c == 12) begin
            check("pin_s6_pend12", int'(pending), 2);
            // Driver pulls reset_n low 2 time units after this edge.
            #3;
            check("pin_s6_async_level", int'(level),    0);
            check("pin_s6_async_busy",  int'(busy),     0);
            check("pin_s6_async_pend",  int'(pending),  0);
            check("pin_s6_async_ovf",   int'(overflow), 0);
          end
          if (cur_c == 21) check("pin_s6_lvl21", int'(level), 1);
          if (cur_c == 24) check("pin_s6_lvl24", int'(level), 1);
          if (cur_c == 25) check("pin_s6_lvl25", int'(level), 0);
        end
        default: ;
      endcase
    end
  end

  task automatic run(input int id, input string name, input logic [63:0] pm, input logic [63:0] cm);
    chk_en  = 1'b0;
    scn     = id;
    p_key   = 1'b0;
    clear   = 1'b0;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    for (int c = 0; c < LEN; c++) begin
      cur_c = c;
      p_key = pm[c];
      clear = cm[c];
      @(negedge clk);
      if (id == 6 && c == 12) begin
        #2;
        reset_n = 1'b0;
        model_reset();
      end
      if (id == 6 && c == 15) begin
        #1;
        reset_n = 1'b1;
      end
      @(posedge clk);
      if (reset_n) model_step(p_key, clear, c);
      #1;
    end
    chk_en = 1'b0;
    p_key  = 1'b0;
    clear  = 1'b0;
    $display("[TB] scenario %0d %s done: %0d tests, %0d failed so far", id, name, tests, fails);
  endtask

  function automatic logic [63:0] bit_at(input int n);
    logic [63:0] v;
    v = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  initial begin
    logic [63:0] sat;
    reset_n = 1'b0;
    p_key   = 1'b0;
    clear   = 1'b0;
    chk_en  = 1'b0;
    scn     = 0;
    cur_c   = 0;
    model_reset();

    sat = '0;
    for (int i = 10; i <= 15; i++) sat = sat | bit_at(i);

    run(1, "single",     bit_at(10), '0);
    run(2, "queueing",   bit_at(10) | bit_at(12) | bit_at(13), '0);
    run(3, "saturation", sat, '0);
    run(4, "boundary",   bit_at(10) | bit_at(16), '0);
    run(5, "clear",      bit_at(10) | bit_at(11) | bit_at(13), bit_at(13));
    run(6, "async_rst",  bit_at(9) | bit_at(10) | bit_at(11) | bit_at(20), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_pulse_stretcher.md
# key_pulse_stretcher

Converts one-cycle event pulses, such as the output of the key-press edge filter, back into timed level windows. Each accepted pulse produces `level` high for exactly `HOLD_CYCLES`, then low for at least `GAP_CYCLES`. Pulses arriving while a window is active are queued in a saturating pending counter and replayed as separate windows. It sits between the input filters and the level-driven consumers (LEDs, sound enable, flap animation).

## Interface
Parameters:
- `HOLD_CYCLES`, default 5_000_000: cycles `level` stays high per event. Must be ≥1.
- `GAP_CYCLES`, default 2_500_000: minimum low cycles between consecutive windows. Must be ≥1.
- `MAX_PENDING`, default 7: saturation value of the event queue. Must be ≥1.

Ports:
- `clk` in 1: system clock. Single clock domain.
- `reset_n` in 1: reset, asynchronous, active-low.
- `p_key` in 1: one-cycle event pulse, synchronous to `clk`.
- `clear` in 1: synchronous abort. Drops the current window and the queue.
- `level` out 1: stretched output window.
- `busy` out 1: high when the state is not IDLE.
- `pending` out `$clog2(MAX_PENDING+1)`: number of queued events.
- `overflow` out 1: one-cycle pulse when an event is dropped because the queue is full.

## Operation
- FSM states are IDLE, HIGH and GAP. A down-counter `cnt` has width `$clog2(max(HOLD_CYCLES,GAP_CYCLES)+1)`.
- Reset (`reset_n`=0, asynchronous) forces all outputs to 0 immediately:
  - state = IDLE, `cnt` = 0, `pending` = 0.
  - `level` = 0, `busy` = 0, `overflow` = 0.
- Transitions from IDLE:
  - `p_key`=1 → HIGH, `cnt` = HOLD_CYCLES-1. `pending` is unchanged.
  - Otherwise stay in IDLE.
- Behaviour in HIGH:
  - `cnt`≠0 → decrement `cnt`.
  - `cnt`=0 → GAP, `cnt` = GAP_CYCLES-1.
- Behaviour in GAP:
  - `cnt`≠0 → decrement `cnt`.
  - `cnt`=0 → evaluate `eff` = `pending` + `p_key`.
  - `eff`>0 → HIGH, `pending` = `eff`-1, `cnt` = HOLD_CYCLES-1.
  - Otherwise → IDLE.
- `p_key` in HIGH, or in GAP with `cnt`≠0:
  - `pending`<MAX_PENDING → `pending`+1.
  - Else `pending` is unchanged and `overflow` pulses for 1 cycle.
- Simultaneous event at the GAP end with `pending`=MAX_PENDING: the net change is 0 and `overflow` does not pulse.
- `clear`=1 has highest priority over every other input:
  - Next state = IDLE, `cnt` = 0, `pending` = 0.
  - `p_key` in the same cycle is ignored, with no `overflow`.
- `p_key` held high for several cycles is treated as one event per cycle. Upstream filtering is the caller's responsibility.

## Timing
- All outputs are registered.
- `level` = (state==HIGH) and `busy` = (state≠IDLE), each taken from the registered state.
- Latency: `p_key` sampled at edge E in IDLE → `level` rises at E, is high for the following HOLD_CYCLES cycles, then is low for GAP_CYCLES cycles.
- With sample edge at cycle N: `level` is high over cycles N+1 … N+HOLD_CYCLES.
- `busy` is high over cycles N+1 … N+HOLD_CYCLES+GAP_CYCLES.
- Back-to-back windows start exactly HOLD_CYCLES+GAP_CYCLES cycles apart.
- `pending` updates on the edge that samples the event.
- `overflow` is high for the cycle after the dropped event's sample edge.
- `clear` at cycle N → `level`, `busy` and `pending` are 0 from cycle N+1.

## Test plan
All scenarios use HOLD_CYCLES=4, GAP_CYCLES=2, MAX_PENDING=3.
- **Single event:** `p_key` at cycle 10 →
  - `level`=1 on cycles 11–14.
  - `busy`=1 on cycles 11–16.
  - IDLE with all outputs 0 from cycle 17.
- **Queueing:** `p_key` at cycles 10, 12, 13 →
  - `pending`=1 at 13, =2 at 14.
  - `level` windows on cycles 11–14, 17–20 and 23–26.
  - `pending`=1 from 17, =0 from 23.
- **Saturation:** `p_key` at cycles 10–15 (6 pulses) →
  - `pending` goes 1, 2, 3, then stays at 3.
  - `overflow`=1 on cycles 15 and 16.
  - Windows at 11–14, 17–20, 23–26 and 29–32.
- **Boundary event:** single event at 10, then `p_key` at 16 (last GAP cycle) →
  - `level`=1 on cycles 17–20.
  - `pending` stays 0 throughout.
  - No `overflow`.
- **Clear:** events at 10 and 11, `clear` plus `p_key` at 13 →
  - From cycle 14: `level`=0, `busy`=0, `pending`=0, `overflow`=0.
  - No further windows.
- **Async reset:** `reset_n` driven low mid-cycle at 12 during HIGH with `pending`=2 →
  - All outputs are 0 before the next `clk` edge.
  - After release, a `p_key` at cycle 20 gives `level` on cycles 21–24 only.
